// File: rtl/nios2_debug_scan_pkg.sv
// Shared types and constants for the Nios II debug-slave scan master.
// Virtual-JTAG state sequence and instruction codes.
package nios2_debug_scan_pkg;

  localparam int DEF_DR_WIDTH = 38;
  localparam int DEF_IR_WIDTH = 2;

  localparam logic [DEF_IR_WIDTH-1:0] IR_OCIMEM    = 2'd0;
  localparam logic [DEF_IR_WIDTH-1:0] IR_TRACEMEM  = 2'd1;
  localparam logic [DEF_IR_WIDTH-1:0] IR_BREAK     = 2'd2;
  localparam logic [DEF_IR_WIDTH-1:0] IR_TRACECTRL = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    UIR,
    CDR,
    SDR,
    UDR,
    RTI,
    DONE
  } state_t;

  // One-hot {uir, cdr, sdr, udr, rti} for a state
  function automatic logic [4:0] strobes(state_t s);
    logic [4:0] v;
    v = 5'b00000;
    case (s)
      UIR:     v = 5'b10000;
      CDR:     v = 5'b01000;
      SDR:     v = 5'b00100;
      UDR:     v = 5'b00010;
      RTI:     v = 5'b00001;
      default: v = 5'b00000;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/nios2_debug_scan_if.sv
// Command/response handshake plus virtual-JTAG pins of the scan master.
// master: the scan engine; slave: the host and debug-slave side.
interface nios2_debug_scan_if #(
  parameter int DR_WIDTH = 38,
  parameter int IR_WIDTH = 2
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [IR_WIDTH-1:0] cmd_ir;
  logic [DR_WIDTH-1:0] cmd_data;
  logic                rsp_valid;
  logic [DR_WIDTH-1:0] rsp_data;
  logic                busy;
  logic                vji_tck;
  logic                vji_tdi;
  logic                vji_tdo;
  logic [IR_WIDTH-1:0] vji_ir_in;
  logic                vji_uir;
  logic                vji_cdr;
  logic                vji_sdr;
  logic                vji_udr;
  logic                vji_rti;

  modport master (
    input  cmd_valid, cmd_ir, cmd_data, vji_tdo,
    output cmd_ready, rsp_valid, rsp_data, busy,
    output vji_tck, vji_tdi, vji_ir_in,
    output vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti
  );

  modport slave (
    output cmd_valid, cmd_ir, cmd_data, vji_tdo,
    input  cmd_ready, rsp_valid, rsp_data, busy,
    input  vji_tck, vji_tdi, vji_ir_in,
    input  vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti
  );

endinterface

// File: rtl/nios2_debug_scan_tckgen.sv
// Divided test clock: low for TCK_HALF clks, then high for TCK_HALF clks.
// Strobes flag the clk edge that will drive TCK high or low.
module nios2_debug_scan_tckgen #(
  parameter int TCK_HALF = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic tck,
  output logic tck_rise_stb,
  output logic tck_fall_stb
);

  localparam int CW = (TCK_HALF > 1) ? $clog2(TCK_HALF) : 1;
  localparam logic [CW-1:0] LAST = CW'(TCK_HALF - 1);

  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap         = en && (cnt == LAST);
  assign tck_rise_stb = wrap && !tck;
  assign tck_fall_stb = wrap && tck;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      tck <= 1'b0;
    end else if (!en) begin
      cnt <= '0;
      tck <= 1'b0;
    end else if (wrap) begin
      cnt <= '0;
      tck <= ~tck;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/nios2_debug_scan_master.sv
// Host-side virtual-JTAG initiator: loads IR, scans one DR word,
// returns the bits shifted out by the Nios II debug slave.
module nios2_debug_scan_master
  import nios2_debug_scan_pkg::*;
#(
  parameter int DR_WIDTH = DEF_DR_WIDTH,
  parameter int IR_WIDTH = DEF_IR_WIDTH,
  parameter int TCK_HALF = 2
) (
  input logic             clk,
  input logic             reset_n,
  nios2_debug_scan_if.master bus
);

  localparam int BW = $clog2(DR_WIDTH + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DR_WIDTH - 1);

  state_t              state;
  logic                cmd_ready;
  logic                busy;
  logic                rsp_valid;
  logic [DR_WIDTH-1:0] rsp_data;
  logic [IR_WIDTH-1:0] ir;
  logic                tdi;
  logic [4:0]          strb;
  logic [DR_WIDTH-1:0] shreg;
  logic [DR_WIDTH-1:0] capreg;
  logic [BW-1:0]       bit_cnt;
  logic                run;
  logic                tck;
  logic                rise;
  logic                fall;

  // TCK stays parked low through the single DONE cycle
  assign run = busy && (state != DONE);

  nios2_debug_scan_tckgen #(
    .TCK_HALF (TCK_HALF)
  ) u_tckgen (
    .clk          (clk),
    .reset_n      (reset_n),
    .en           (run),
    .tck          (tck),
    .tck_rise_stb (rise),
    .tck_fall_stb (fall)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      ir        <= '0;
      tdi       <= 1'b0;
      strb      <= '0;
      shreg     <= '0;
      capreg    <= '0;
      bit_cnt   <= '0;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (bus.cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            ir        <= bus.cmd_ir;
            shreg     <= bus.cmd_data;
            bit_cnt   <= '0;
            state     <= UIR;
            strb      <= strobes(UIR);
          end
        end
        UIR: begin
          if (fall) begin
            state <= CDR;
            strb  <= strobes(CDR);
          end
        end
        CDR: begin
          if (fall) begin
            state <= SDR;
            strb  <= strobes(SDR);
            tdi   <= shreg[0];
          end
        end
        SDR: begin
          if (rise) begin
            capreg <= {bus.vji_tdo, capreg[DR_WIDTH-1:1]};
          end
          if (fall) begin
            shreg <= shreg >> 1;
            if (bit_cnt == LAST_BIT) begin
              state <= UDR;
              strb  <= strobes(UDR);
              tdi   <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
              tdi     <= shreg[1];
            end
          end
        end
        UDR: begin
          if (fall) begin
            state <= RTI;
            strb  <= strobes(RTI);
          end
        end
        RTI: begin
          if (fall) begin
            state <= DONE;
            strb  <= strobes(DONE);
          end
        end
        DONE: begin
          state     <= IDLE;
          rsp_valid <= 1'b1;
          rsp_data  <= capreg;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.busy      = busy;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_data  = rsp_data;
  assign bus.vji_tck   = tck;
  assign bus.vji_tdi   = tdi;
  assign bus.vji_ir_in = ir;
  assign bus.vji_uir   = strb[4];
  assign bus.vji_cdr   = strb[3];
  assign bus.vji_sdr   = strb[2];
  assign bus.vji_udr   = strb[1];
  assign bus.vji_rti   = strb[0];

endmodule

// File: tb/tb_nios2_debug_scan_master.sv
// Bench for the scan master: loopback debug-slave models, a
// time-offset reference model, and directed plus random scans.
module tb_nios2_debug_scan_master;
  import nios2_debug_scan_pkg::*;

  localparam int DW = 38;
  localparam int IW = 2;
  localparam int HA = 2;
  localparam int HB = 1;
  localparam int LAT_A = (DW + 4) * 2 * HA + 1;
  localparam int LAT_B = (DW + 4) * 2 * HB + 1;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  nios2_debug_scan_if #(.DR_WIDTH(DW), .IR_WIDTH(IW)) bus_a ();
  nios2_debug_scan_if #(.DR_WIDTH(DW), .IR_WIDTH(IW)) bus_b ();

  nios2_debug_scan_master #(
    .DR_WIDTH(DW), .IR_WIDTH(IW), .TCK_HALF(HA)
  ) dut_a (.clk(clk), .reset_n(reset_n), .bus(bus_a));

  nios2_debug_scan_master #(
    .DR_WIDTH(DW), .IR_WIDTH(IW), .TCK_HALF(HB)
  ) dut_b (.clk(clk), .reset_n(reset_n), .bus(bus_b));

  // loopback debug slaves: tdo = sr[0], shift tdi in on each TCK rise in SDR
  logic [DW-1:0] sl_a, sl_a_val, sl_b, sl_b_val;
  logic sl_a_ld = 1'b0, sl_b_ld = 1'b0;
  logic tck_a_q = 1'b0, tck_b_q = 1'b0;

  always @(posedge clk) begin
    tck_a_q <= bus_a.vji_tck;
    if (sl_a_ld) sl_a <= sl_a_val;
    else if (!tck_a_q && bus_a.vji_tck && bus_a.vji_sdr)
      sl_a <= {bus_a.vji_tdi, sl_a[DW-1:1]};
  end

  always @(posedge clk) begin
    tck_b_q <= bus_b.vji_tck;
    if (sl_b_ld) sl_b <= sl_b_val;
    else if (!tck_b_q && bus_b.vji_tck && bus_b.vji_sdr)
      sl_b <= {bus_b.vji_tdi, sl_b[DW-1:1]};
  end

  assign bus_a.vji_tdo = sl_a[0];
  assign bus_b.vji_tdo = sl_b[0];

  // reference model for instance A: time since acceptance
  bit            m_act, m_ready, m_rspv;
  int            m_t;
  logic [DW-1:0] m_rsp, m_exp, m_data;
  logic [IW-1:0] m_ir;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_act <= 0; m_ready <= 0; m_rspv <= 0; m_t <= 0;
      m_rsp <= '0; m_ir <= '0; m_data <= '0; m_exp <= '0;
    end else begin
      m_rspv <= 0;
      if (m_act) begin
        m_t <= m_t + 1;
        if (m_t + 1 == LAT_A) begin
          m_act <= 0; m_ready <= 1; m_rspv <= 1; m_rsp <= m_exp;
        end
      end else if (m_ready && bus_a.cmd_valid) begin
        m_act <= 1; m_ready <= 0; m_t <= 0;
        m_ir <= bus_a.cmd_ir; m_data <= bus_a.cmd_data; m_exp <= sl_a;
      end else begin
        m_ready <= 1;
      end
    end
  end

  // {cmd_ready, busy, rsp_valid, tck, tdi, uir, cdr, sdr, udr, rti}
  function automatic logic [9:0] exp_ctl(bit act, bit rdy, bit rv, int t,
                                         logic [DW-1:0] d);
    int p, ph;
    logic [4:0] s;
    logic tk, ti;
    s = '0; tk = 1'b0; ti = 1'b0;
    if (act && t < LAT_A - 1) begin
      p = t / (2 * HA);
      ph = t % (2 * HA);
      tk = (ph >= HA);
      if (p == 0) s = 5'b10000;
      else if (p == 1) s = 5'b01000;
      else if (p < DW + 2) begin s = 5'b00100; ti = d[p-2]; end
      else if (p == DW + 2) s = 5'b00010;
      else s = 5'b00001;
    end
    return {rdy, act, rv, tk, ti, s};
  endfunction

  function automatic logic [9:0] ctl_a();
    return {bus_a.cmd_ready, bus_a.busy, bus_a.rsp_valid, bus_a.vji_tck,
            bus_a.vji_tdi, bus_a.vji_uir, bus_a.vji_cdr, bus_a.vji_sdr,
            bus_a.vji_udr, bus_a.vji_rti};
  endfunction

  function automatic logic [9:0] ctl_b();
    return {bus_b.cmd_ready, bus_b.busy, bus_b.rsp_valid, bus_b.vji_tck,
            bus_b.vji_tdi, bus_b.vji_uir, bus_b.vji_cdr, bus_b.vji_sdr,
            bus_b.vji_udr, bus_b.vji_rti};
  endfunction

  task automatic check(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // monitors
  bit mon_en = 0, mon_b = 0, prev_ok = 0;
  int c_uir, c_cdr, c_sdr, c_udr, c_rti, tdi_bad, b_rises;
  logic p_tck = 0, p_tdi = 0, p_tck_b = 0;

  task automatic compare();
    if (!reset_n) begin
      check("reset_a", 64'({ctl_a(), bus_a.rsp_data, bus_a.vji_ir_in}), 64'(0));
      check("reset_b", 64'({ctl_b(), bus_b.rsp_data, bus_b.vji_ir_in}), 64'(0));
    end else begin
      check("ctl_a", 64'(ctl_a()),
            64'(exp_ctl(m_act, m_ready, m_rspv, m_t, m_data)));
      check("rsp_data_a", 64'(bus_a.rsp_data), 64'(m_rsp));
      check("ir_a", 64'(bus_a.vji_ir_in), 64'(m_ir));
    end
  endtask

  task automatic monitor();
    if (reset_n && prev_ok && bus_a.vji_tdi != p_tdi &&
        !(p_tck && !bus_a.vji_tck)) tdi_bad++;
    if (mon_en) begin
      c_uir += int'(bus_a.vji_uir); c_cdr += int'(bus_a.vji_cdr);
      c_sdr += int'(bus_a.vji_sdr); c_udr += int'(bus_a.vji_udr);
      c_rti += int'(bus_a.vji_rti);
    end
    if (mon_b && bus_b.vji_tck && !p_tck_b) b_rises++;
    p_tck = bus_a.vji_tck; p_tdi = bus_a.vji_tdi;
    p_tck_b = bus_b.vji_tck; prev_ok = reset_n;
  endtask

  task automatic tick();
    @(negedge clk);
    compare();
    monitor();
  endtask

  function automatic logic [DW-1:0] rand38();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[DW-1:0];
  endfunction

  task automatic load_a(input logic [DW-1:0] v);
    sl_a_val = v; sl_a_ld = 1'b1;
    tick();
    sl_a_ld = 1'b0;
  endtask

  task automatic wait_ready_a();
    int k;
    k = 0;
    while (!bus_a.cmd_ready && k < 50) begin tick(); k++; end
    check("ready_wait_a", 64'(bus_a.cmd_ready), 64'(1));
  endtask

  // one scan on A; lat = clk edges from acceptance to rsp_valid
  task automatic run_a(input logic [IW-1:0] ir, input logic [DW-1:0] d,
                       input logic [DW-1:0] pre, input bit noise,
                       output logic [DW-1:0] rsp, output int lat);
    bit seen;
    load_a(pre);
    wait_ready_a();
    bus_a.cmd_valid = 1'b1; bus_a.cmd_ir = ir; bus_a.cmd_data = d;
    tick();
    bus_a.cmd_valid = 1'b0;
    lat = 0; seen = 0;
    while (!seen && lat < 400) begin
      if (noise) begin
        bus_a.cmd_valid = (lat < 150) && ($urandom_range(0, 1) == 1);
        bus_a.cmd_ir = IW'($urandom_range(0, 3));
        bus_a.cmd_data = rand38();
      end
      tick(); lat++;
      if (bus_a.rsp_valid) seen = 1;
    end
    bus_a.cmd_valid = 1'b0;
    check("rsp_seen_a", 64'(seen), 64'(1));
    rsp = bus_a.rsp_data;
  endtask

  initial begin
    logic [DW-1:0] rsp, rsp1, rsp2, p, d;
    logic [IW-1:0] ir1, ir2;
    int lat, k, n_rsp, k1, acc_k;
    bus_a.cmd_valid = 0; bus_a.cmd_ir = '0; bus_a.cmd_data = '0;
    bus_b.cmd_valid = 0; bus_b.cmd_ir = '0; bus_b.cmd_data = '0;
    sl_a_val = '0; sl_b_val = '0;
    c_uir = 0; c_cdr = 0; c_sdr = 0; c_udr = 0; c_rti = 0;
    tdi_bad = 0; b_rises = 0;
    #1 reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    check("ready_after_reset", 64'(bus_a.cmd_ready), 64'(1));

    // directed loopback scan with strobe timing
    mon_en = 1;
    run_a(IR_BREAK, 38'h2A_F00F_0FF0, 38'h15_A5A5_5A5A, 1'b0, rsp, lat);
    mon_en = 0;
    check("dir_latency", 64'(lat), 64'(169));
    check("dir_rsp", 64'(rsp), 64'(38'h15_A5A5_5A5A));
    check("dir_slave_sr", 64'(sl_a), 64'(38'h2A_F00F_0FF0));
    check("dir_ir", 64'(bus_a.vji_ir_in), 64'(2));
    check("uir_cycles", 64'(c_uir), 64'(4));
    check("cdr_cycles", 64'(c_cdr), 64'(4));
    check("sdr_cycles", 64'(c_sdr), 64'(152));
    check("udr_cycles", 64'(c_udr), 64'(4));
    check("rti_cycles", 64'(c_rti), 64'(4));

    // back-to-back with cmd_valid held high
    load_a(38'h0A_1234_5678);
    wait_ready_a();
    bus_a.cmd_valid = 1; bus_a.cmd_ir = IR_OCIMEM; bus_a.cmd_data = 38'h33_CAFE_0001;
    tick();
    bus_a.cmd_ir = IR_TRACECTRL; bus_a.cmd_data = 38'h01_0203_0405;
    n_rsp = 0; k = 0; k1 = 0; acc_k = -1; rsp1 = '0; rsp2 = '0; ir1 = '0; ir2 = '0;
    while (n_rsp < 2 && k < 600) begin
      tick(); k++;
      if (bus_a.rsp_valid) begin
        n_rsp++;
        if (n_rsp == 1) begin rsp1 = bus_a.rsp_data; ir1 = bus_a.vji_ir_in; k1 = k; end
        else begin rsp2 = bus_a.rsp_data; ir2 = bus_a.vji_ir_in; end
      end
      if (n_rsp == 1 && bus_a.busy && acc_k < 0) begin
        acc_k = k; bus_a.cmd_valid = 0;
      end
    end
    bus_a.cmd_valid = 0;
    repeat (20) begin tick(); if (bus_a.rsp_valid) n_rsp++; end
    check("b2b_pulses", 64'(n_rsp), 64'(2));
    check("b2b_gap", 64'(acc_k - k1), 64'(1));
    check("b2b_rsp1", 64'(rsp1), 64'(38'h0A_1234_5678));
    check("b2b_rsp2", 64'(rsp2), 64'(38'h33_CAFE_0001));
    check("b2b_ir1", 64'(ir1), 64'(0));
    check("b2b_ir2", 64'(ir2), 64'(3));
    check("b2b_slave", 64'(sl_a), 64'(38'h01_0203_0405));

    // reset during SDR bit 17
    load_a(rand38());
    wait_ready_a();
    bus_a.cmd_valid = 1; bus_a.cmd_ir = IR_TRACEMEM; bus_a.cmd_data = rand38();
    tick();
    bus_a.cmd_valid = 0;
    k = 0;
    while (k < (17 + 2) * 2 * HA + 1) begin tick(); k++; end
    check("pre_reset_sdr", 64'(bus_a.vji_sdr), 64'(1));
    reset_n = 1'b0;
    #1;
    check("rst_vji_now", 64'({bus_a.vji_tck, bus_a.vji_tdi, bus_a.vji_uir,
          bus_a.vji_cdr, bus_a.vji_sdr, bus_a.vji_udr, bus_a.vji_rti,
          bus_a.vji_ir_in}), 64'(0));
    check("rst_busy_now", 64'({bus_a.busy, bus_a.rsp_valid}), 64'(0));
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    check("rst_ready", 64'(bus_a.cmd_ready), 64'(1));
    p = rand38(); d = rand38();
    run_a(IR_BREAK, d, p, 1'b0, rsp, lat);
    check("post_rst_lat", 64'(lat), 64'(LAT_A));
    check("post_rst_rsp", 64'(rsp), 64'(p));
    check("post_rst_slave", 64'(sl_a), 64'(d));

    // randomized scans with ignored requests while busy
    for (int n = 0; n < 6; n++) begin
      p = rand38(); d = rand38();
      repeat ($urandom_range(0, 5)) tick();
      run_a(IW'($urandom_range(0, 3)), d, p, 1'b1, rsp, lat);
      check("rnd_lat", 64'(lat), 64'(LAT_A));
      check("rnd_rsp", 64'(rsp), 64'(p));
      check("rnd_slave", 64'(sl_a), 64'(d));
    end
    check("tdi_only_at_fall", 64'(tdi_bad), 64'(0));

    // TCK_HALF = 1 instance
    sl_b_val = '0; sl_b_ld = 1'b1;
    tick();
    sl_b_ld = 1'b0;
    check("b_ready", 64'(bus_b.cmd_ready), 64'(1));
    bus_b.cmd_valid = 1; bus_b.cmd_ir = IR_BREAK; bus_b.cmd_data = 38'h3F_FFFF_FFFF;
    mon_b = 1;
    tick();
    bus_b.cmd_valid = 0;
    lat = 0;
    while (!bus_b.rsp_valid && lat < 400) begin tick(); lat++; end
    mon_b = 0;
    check("b_latency", 64'(lat), 64'(85));
    check("b_rsp", 64'(bus_b.rsp_data), 64'(0));
    check("b_slave", 64'(sl_b), 64'(38'h3F_FFFF_FFFF));
    check("b_tck_rises", 64'(b_rises), 64'(DW + 4));
    check("b_lat_formula", 64'(lat), 64'(LAT_B));
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
